// File: rtl/uart_rx_deserializer_pkg.sv
// uart_rx_deserializer_pkg
// Shared definitions for the UART receive path:
//   - receiver state encoding
//   - RX FIFO word layout (data / break / framing error / parity error)
//   - line control register field positions
//   - frame length helper used by the character timeout
package uart_rx_deserializer_pkg;

    localparam int UART_FIFO_WIDTH = 11;

    // RX FIFO word bit positions
    localparam int FW_PE       = 0;
    localparam int FW_FE       = 1;
    localparam int FW_BRK      = 2;
    localparam int FW_DATA_LSB = 3;

    // Line control register fields
    localparam int LCR_WLS_LSB = 0;   // [1:0] word length 5..8
    localparam int LCR_STB     = 2;   // 0: one stop bit, 1: two
    localparam int LCR_PEN     = 3;   // parity enable
    localparam int LCR_EPS     = 4;   // even parity select
    localparam int LCR_SP      = 5;   // stick parity

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

    // Bits per character: start + data + parity + stop(s). Range 7..12.
    function automatic logic [3:0] frame_bits(input logic [5:0] lcr);
        return 4'd7 + {2'b00, lcr[LCR_WLS_LSB +: 2]}
                    + {3'b000, lcr[LCR_PEN]}
                    + {3'b000, lcr[LCR_STB]};
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
// Push side of the RX FIFO as seen by the receive deserializer.
//   rf_push     one-cycle push strobe            (deserializer -> FIFO)
//   rf_data_in  word to push, valid with rf_push (deserializer -> FIFO)
//   rf_count    current FIFO occupancy           (FIFO -> deserializer)
//   rf_pop      FIFO pop strobe                  (FIFO -> deserializer)
interface uart_rx_deserializer_if;
    import uart_rx_deserializer_pkg::*;

    logic                       rf_push;
    logic [UART_FIFO_WIDTH-1:0] rf_data_in;
    logic [4:0]                 rf_count;
    logic                       rf_pop;

    modport master (
        output rf_push,
        output rf_data_in,
        input  rf_count,
        input  rf_pop
    );

    modport slave (
        input  rf_push,
        input  rf_data_in,
        output rf_count,
        output rf_pop
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Synchroniser chain for the asynchronous serial input. Flops reset to 1
// so the line looks idle while in reset.
//   clk    system clock
//   rstnn  asynchronous active-low reset
//   d_i    raw asynchronous input
//   q_o    synchronised output
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstnn,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// UART receive front-end. Oversamples the RX pin on a 16x baud tick, frames
// each character and pushes {data, break, framing_err, parity_err} into the
// RX FIFO. Also runs the character timeout counter.
//   clk         system clock
//   rstnn       asynchronous active-low reset
//   enable      16x baud tick, one clk wide
//   srx_pad_i   raw serial input, idle high
//   lcr         line control (word length, stop bits, parity controls)
//   rf_if       RX FIFO push side (push/data out, count/pop in)
//   rx_busy     receiver is not idle
//   rx_break    break condition on the line
//   rx_timeout  character timeout
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge
// START      | confirming the start bit at its centre
// DATA       | sampling data bits at each bit centre
// PARITY     | sampling the parity bit
// STOP       | sampling the first stop bit, building the FIFO word
// PUSH       | rf_push high for one clk (does not wait for enable)
// WAIT_IDLE  | break seen, waiting for the line to return high
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TOUT_CHARS  = 4
) (
    input  logic                           clk,
    input  logic                           rstnn,
    input  logic                           enable,
    input  logic                           srx_pad_i,
    input  logic [5:0]                     lcr,
    uart_rx_deserializer_if.master         rf_if,
    output logic                           rx_busy,
    output logic                           rx_break,
    output logic                           rx_timeout
);

    logic srx_s;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rstnn (rstnn),
        .d_i   (srx_pad_i),
        .q_o   (srx_s)
    );

    rx_state_e                  state_q;
    logic [3:0]                 scnt_q;
    logic [2:0]                 bitcnt_q;
    logic [7:0]                 data_q;
    logic                       par_bit_q;
    logic                       pe_q;
    logic                       rf_push_q;
    logic [UART_FIFO_WIDTH-1:0] rf_data_q;
    logic                       rx_break_q;
    logic [9:0]                 tcnt_q;
    logic [9:0]                 tcnt_d;

    logic [2:0]                 last_bit;
    logic                       par_calc;
    logic                       par_err;
    logic                       line_break;
    logic [UART_FIFO_WIDTH-1:0] word_d;
    logic [9:0]                 tout_thr;

    // Index of the final data bit: word length minus one.
    assign last_bit = 3'd4 + {1'b0, lcr[LCR_WLS_LSB +: 2]};

    // Stick parity compares the sampled bit alone; normal parity folds in
    // the data. Either way the result must equal ~EPS.
    assign par_calc = lcr[LCR_SP] ? srx_s : (^data_q ^ srx_s);
    assign par_err  = (par_calc != ~lcr[LCR_EPS]);

    assign line_break = (data_q == 8'h00)
                      && (!lcr[LCR_PEN] || !par_bit_q)
                      && !srx_s;

    always_comb begin
        word_d = '0;
        if (line_break) begin
            word_d[FW_BRK] = 1'b1;
            word_d[FW_FE]  = 1'b1;
            word_d[FW_PE]  = pe_q;
        end else begin
            word_d[FW_DATA_LSB +: 8] = data_q;
            word_d[FW_FE]            = ~srx_s;
            word_d[FW_PE]            = pe_q;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            bitcnt_q   <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            pe_q       <= 1'b0;
            rf_push_q  <= 1'b0;
            rf_data_q  <= '0;
            rx_break_q <= 1'b0;
        end else begin
            rf_push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !srx_s) begin
                        state_q <= ST_START;
                        scnt_q  <= '0;
                    end
                end
                ST_START: begin
                    if (enable) begin
                        if (scnt_q == 4'd7) begin
                            if (srx_s) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q   <= ST_DATA;
                                scnt_q    <= '0;
                                bitcnt_q  <= '0;
                                data_q    <= '0;
                                par_bit_q <= 1'b0;
                                pe_q      <= 1'b0;
                            end
                        end else begin
                            scnt_q <= scnt_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (enable) begin
                        scnt_q <= scnt_q + 4'd1;
                        if (scnt_q == 4'd15) begin
                            // Writing bit n at index n is LSB-first shifting
                            // with the result already right-aligned.
                            data_q[bitcnt_q] <= srx_s;
                            bitcnt_q         <= bitcnt_q + 3'd1;
                            // >= keeps the exit reachable if lcr shrinks mid-frame.
                            if (bitcnt_q >= last_bit) begin
                                state_q <= lcr[LCR_PEN] ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (enable) begin
                        scnt_q <= scnt_q + 4'd1;
                        if (scnt_q == 4'd15) begin
                            par_bit_q <= srx_s;
                            pe_q      <= par_err;
                            state_q   <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        scnt_q <= scnt_q + 4'd1;
                        if (scnt_q == 4'd15) begin
                            rf_push_q  <= 1'b1;
                            rf_data_q  <= word_d;
                            rx_break_q <= line_break;
                            state_q    <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    state_q <= rx_break_q ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (enable && srx_s) begin
                        rx_break_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Character timeout: TOUT_CHARS character times of 16 ticks per bit.
    assign tout_thr = 10'(TOUT_CHARS * 16) * {6'b000000, frame_bits(lcr)};

    always_comb begin
        tcnt_d = tcnt_q;
        if (rf_push_q || rf_if.rf_pop || (rf_if.rf_count == 5'd0)) begin
            tcnt_d = '0;
        end else if (tcnt_q > tout_thr) begin
            // Threshold dropped after an lcr change.
            tcnt_d = tout_thr;
        end else if (enable && (tcnt_q != tout_thr)) begin
            tcnt_d = tcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign rf_if.rf_push    = rf_push_q;
    assign rf_if.rf_data_in = rf_data_q;
    assign rx_busy          = (state_q != ST_IDLE);
    assign rx_break         = rx_break_q;
    assign rx_timeout       = (tcnt_q == tout_thr);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;
    import uart_rx_deserializer_pkg::*;

    logic       clk       = 1'b0;
    logic       rstnn     = 1'b0;
    logic       enable    = 1'b0;
    logic       srx_pad_i = 1'b1;
    logic [5:0] lcr       = 6'b000011;
    logic       rx_busy;
    logic       rx_break;
    logic       rx_timeout;

    uart_rx_deserializer_if rf_if ();

    uart_rx_deserializer #(
        .SYNC_STAGES (2),
        .TOUT_CHARS  (4)
    ) dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .enable     (enable),
        .srx_pad_i  (srx_pad_i),
        .lcr        (lcr),
        .rf_if      (rf_if),
        .rx_busy    (rx_busy),
        .rx_break   (rx_break),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [10:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // 16x tick: one clk high out of every four
    initial begin
        forever begin
            repeat (3) begin
                @(negedge clk);
                enable = 1'b0;
            end
            @(negedge clk);
            enable = 1'b1;
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            logic [10:0] e;
            @(negedge clk);
            if (rf_if.rf_push === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push actual=%0h required=none", rf_if.rf_data_in);
                end else begin
                    e = sb.pop_front();
                    chk("push_word", 32'(rf_if.rf_data_in), 32'(e));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (enable !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Reference: expected FIFO word from the character as it appears on the wire.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [5:0] l,
                                          input bit flip, input bit stop, output bit pbit);
        int nb;
        logic [7:0] dm;
        logic x, want, pe, brk;
        nb = 5 + int'(l[1:0]);
        dm = '0;
        for (int i = 0; i < nb; i++) dm[i] = d[i];
        x = ^dm;
        if (l[5]) want = ~l[4];
        else      want = l[4] ? x : ~x;
        pbit = want ^ flip;
        pe   = l[3] & flip;
        brk  = (dm == 8'h00) && (!l[3] || !pbit) && !stop;
        if (brk) return {8'h00, 1'b1, 1'b1, pe};
        return {dm, 1'b0, ~stop, pe};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [5:0] l,
                              input bit flip, input bit bad_stop);
        bit pbit;
        int nb;
        nb = 5 + int'(l[1:0]);
        lcr = l;
        sb.push_back(model(d, l, flip, !bad_stop, pbit));
        srx_pad_i = 1'b0;
        tick_wait(16);
        for (int i = 0; i < nb; i++) begin
            srx_pad_i = d[i];
            tick_wait(16);
        end
        if (l[3]) begin
            srx_pad_i = pbit;
            tick_wait(16);
        end
        if (bad_stop) begin
            srx_pad_i = 1'b0;
            tick_wait(10);
            srx_pad_i = 1'b1;
            tick_wait(22);
        end else begin
            srx_pad_i = 1'b1;
            tick_wait(16);
        end
        if (l[2]) begin
            srx_pad_i = 1'b1;
            tick_wait(16);
        end
        srx_pad_i = 1'b1;
        tick_wait(32);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        logic [5:0] l;
        bit flip, bad;

        rf_if.rf_count = 5'd0;
        rf_if.rf_pop   = 1'b0;
        rstnn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_push", rf_if.rf_push, 0);
        chk("reset_data", rf_if.rf_data_in, 0);
        chk("reset_busy", rx_busy, 0);
        chk("reset_break", rx_break, 0);
        chk("reset_timeout", rx_timeout, 0);
        @(negedge clk);
        rstnn = 1'b1;
        tick_wait(8);

        // 8N1 0xA5
        send_frame(8'hA5, 6'b000011, 1'b0, 1'b0);
        drain("drain_8n1");
        chk("busy_after_8n1", rx_busy, 0);

        // 7E1 0x41, correct then flipped parity
        send_frame(8'h41, 6'b011010, 1'b0, 1'b0);
        send_frame(8'h41, 6'b011010, 1'b1, 1'b0);
        drain("drain_7e1");

        // Start-bit glitch
        lcr = 6'b000011;
        srx_pad_i = 1'b0;
        tick_wait(5);
        chk("glitch_busy_mid", rx_busy, 1);
        srx_pad_i = 1'b1;
        tick_wait(8);
        chk("glitch_busy_end", rx_busy, 0);
        tick_wait(16);

        // Long break then a clean frame
        sb.push_back(11'b00000000_110);
        srx_pad_i = 1'b0;
        tick_wait(480);
        chk("break_high", rx_break, 1);
        drain("drain_break");
        srx_pad_i = 1'b1;
        tick_wait(3);
        chk("break_low", rx_break, 0);
        tick_wait(16);
        send_frame(8'h55, 6'b000011, 1'b0, 1'b0);
        drain("drain_after_break");

        // Character timeout
        lcr = 6'b000011;
        rf_if.rf_count = 5'd3;
        @(negedge clk);
        rf_if.rf_pop = 1'b1;
        @(posedge clk);
        #1;
        rf_if.rf_pop = 1'b0;
        n = 0;
        while (rx_timeout !== 1'b1 && n < 1000) begin
            @(posedge clk);
            if (enable === 1'b1) n++;
            #1;
        end
        chk("timeout_ticks", n, 640);
        tick_wait(5);
        chk("timeout_sticky", rx_timeout, 1);
        @(negedge clk);
        rf_if.rf_pop = 1'b1;
        @(posedge clk);
        #1;
        rf_if.rf_pop = 1'b0;
        chk("timeout_clear", rx_timeout, 0);
        rf_if.rf_count = 5'd0;
        tick_wait(4);

        // Reset during data bit 4
        lcr = 6'b000011;
        d = 8'h3C;
        srx_pad_i = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 4; i++) begin
            srx_pad_i = d[i];
            tick_wait(16);
        end
        srx_pad_i = d[4];
        tick_wait(8);
        chk("pre_reset_busy", rx_busy, 1);
        rstnn = 1'b0;
        #1;
        chk("mid_reset_busy", rx_busy, 0);
        chk("mid_reset_push", rf_if.rf_push, 0);
        chk("mid_reset_data", rf_if.rf_data_in, 0);
        chk("mid_reset_break", rx_break, 0);
        srx_pad_i = 1'b1;
        repeat (6) @(negedge clk);
        rstnn = 1'b1;
        tick_wait(32);
        send_frame(8'h96, 6'b000011, 1'b0, 1'b0);
        drain("drain_after_reset");

        // Randomized frames across all line settings
        for (int k = 0; k < 20; k++) begin
            l    = 6'($urandom_range(0, 63));
            d    = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            flip = ($urandom_range(0, 3) == 0);
            bad  = ($urandom_range(0, 7) == 0);
            send_frame(d, l, flip, bad);
        end
        drain("drain_random");
        chk("busy_final", rx_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive front-end of the UART. Samples the serial RX pin at 16x the baud rate and frames each character from start to stop.
- Pushes one 11-bit word per character into the RX FIFO: {data[7:0], break, framing_err, parity_err}.
- Also generates the character-timeout indication used by the interrupt/status logic.
- Sits between the RX pad and the RX FIFO. It has no backpressure: the FIFO handles overrun.

Parameters:
- UART_FIFO_WIDTH, 11, width of the pushed word: [10:3] data, [2] break, [1] framing error, [0] parity error.
- SYNC_STAGES, 2, number of synchroniser flops on the serial input (minimum 2).
- TOUT_CHARS, 4, character times without FIFO activity before the timeout is raised.

Ports:
- clk  in  1  system clock
- rstnn  in  1  asynchronous, active-low reset
- enable  in  1  16x baud tick, one clk wide
- srx_pad_i  in  1  raw serial input; idle is high
- lcr  in  6  line control:
  - [1:0] word length 5/6/7/8
  - [2] stop bits 1/2
  - [3] parity enable
  - [4] even parity
  - [5] stick parity
- rf_count  in  5  current RX FIFO occupancy
- rf_pop  in  1  RX FIFO pop strobe
- rf_push  out  1  one-cycle push strobe
- rf_data_in  out  UART_FIFO_WIDTH  word to push; valid while rf_push=1
- rx_busy  out  1  1 in any state other than IDLE
- rx_break  out  1  break condition currently on the line
- rx_timeout  out  1  character timeout, sticky until cleared

Behaviour:
- Reset values: every output is 0; state=IDLE; synchroniser flops are 1; all counters are 0.
- Everything advances only on a cycle where enable=1. The one exception is rf_push, which is a single clk pulse.
- srx_s is srx_pad_i after SYNC_STAGES flops.
- A 4-bit sample counter, scnt, counts enable ticks within a bit.
- State machine:
  - IDLE: on srx_s=0 go to START with scnt=0.
  - START: at scnt=7, if srx_s=1 this was a glitch, so return to IDLE; otherwise set scnt=0 and go to DATA.
  - DATA: each bit is sampled at scnt=15, i.e. the bit centre. Shift LSB-first into an 8-bit register. Unused upper bits are zero for word lengths below 8. After 5+lcr[1:0] bits go to PARITY if lcr[3]=1, else to STOP.
  - PARITY: sample at scnt=15.
    - Normal: parity_err = (XOR of data bits XOR sampled bit) != ~lcr[4], i.e. even parity expects the total XOR to be 0.
    - Stick (lcr[5]=1): the expected bit is ~lcr[4].
  - STOP: sample at scnt=15.
    - framing_err = ~srx_s.
    - Break = data==0, parity bit==0 (if enabled), and stop==0.
    - Go to PUSH.
    - The second stop bit is never checked. Sampling resumes from IDLE, so back-to-back frames are accepted.
  - PUSH: this state does not wait for enable.
    - rf_push=1 for exactly one clk.
    - On break, the pushed word is data=0, bit[2]=1, bit[1]=1.
    - Next state is WAIT_IDLE if break, else IDLE.
  - WAIT_IDLE: rx_break=1 until srx_s=1 on an enable tick, then go to IDLE. Only one word is pushed per break.
- Push latency is 1 clk after the enable tick that samples the stop bit.
- Timeout counter, 10 bits:
  - Frame bits F = 1 + (5+lcr[1:0]) + lcr[3] + 1 + lcr[2]. Maximum F is 12.
  - Threshold = TOUT_CHARS × 16 × F.
  - The counter clears when rf_push, rf_pop or rf_count==0; clearing has priority over counting.
  - Otherwise it increments on enable, saturating at the threshold.
  - rx_timeout=1 while the counter equals the threshold.
- lcr changes mid-frame give undefined data, but the FSM must still return to IDLE within 13 bit times.
- rstnn asserted mid-frame aborts the frame immediately with no push.

Decomposition:
- Shared package/header (extends the existing UART defines):
  - state encoding
  - FIFO word bit positions (BRK=2, FE=1, PE=0)
  - UART_FIFO_WIDTH
  - LCR field positions
- One natural sub-module, uart_rx_sync: the SYNC_STAGES flop chain with reset-to-1. All other logic stays inline.

Test Plan:
- 8N1, 0xA5 sent at 16 ticks/bit -> one rf_push; rf_data_in = 11'b10100101_000; rx_busy returns to 0.
- 7E1, data 0x41 with a correct parity bit (0) -> word {0x41,000}. Repeat with the parity bit flipped -> bit[0]=1.
- Start-bit glitch: srx low for 5 ticks -> no push; state back to IDLE; rx_busy=0 within 8 ticks.
- Line held low for 3 frame times, 8N1 -> exactly one push of 11'b00000000_110. rx_break=1 until the line rises, then a following 0x55 frame is received cleanly.
- Timeout: rf_count=3, no pop/push, 8N1 -> rx_timeout rises after exactly 640 enable ticks. An rf_pop clears it on the next clk.
- Reset mid-DATA: rstnn low during bit 4 -> outputs 0 immediately, no push. The next full frame is received correctly.
